// File: rtl/opo_lock_servo.sv
// opo_lock_servo: lock acquisition (sweep) and saturating PI servo for the OPO cavity.
// Consumes demodulated error samples, sweeps the DAC until resonance is seen, then
// closes a PI loop with anti-windup and reports IDLE/SCAN/ACQ/LOCK.
// Optional build macro OPO_SERVO_DERIV_EN adds a kd input and a derivative term.
// Pipeline: stage 1 registers |err| and gain products, stage 2 updates integrator,
// counters, state and dac_out. A sample that leaves ACQ/LOCK for SCAN holds dac_out;
// the ramp resumes from that value on the next sample.
module opo_lock_servo #(
  parameter int CART_LENGTH  = 24,
  parameter int DAC_LENGTH   = 14,
  parameter int GAIN_LENGTH  = 16,
  parameter int SHIFT        = 12,
  parameter int ACC_LENGTH   = 48,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [CART_LENGTH-1:0] err_in,
  input  logic                          err_valid,
  input  logic signed [GAIN_LENGTH-1:0] kp,
  input  logic signed [GAIN_LENGTH-1:0] ki,
`ifdef OPO_SERVO_DERIV_EN
  input  logic signed [GAIN_LENGTH-1:0] kd,
`endif
  input  logic        [CART_LENGTH-1:0] lock_thresh,
  input  logic        [CART_LENGTH-1:0] unlock_thresh,
  input  logic        [DAC_LENGTH-1:0]  scan_step,
  input  logic signed [DAC_LENGTH-1:0]  scan_min,
  input  logic signed [DAC_LENGTH-1:0]  scan_max,
  output logic signed [DAC_LENGTH-1:0]  dac_out,
  output logic                          dac_valid,
  output logic        [1:0]             state_out,
  output logic                          locked
);

  localparam int PROD_W  = CART_LENGTH + GAIN_LENGTH;
  localparam int SUM_W   = ACC_LENGTH + 2;
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CART_LENGTH-1:0] ABS_MAX = {1'b0, {(CART_LENGTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_ACQ = 2'd2, S_LOCK = 2'd3} state_e;

  state_e state_q, state_d;

  // stage 1
  logic                     accept;
  logic [1:0]               vld_pipe_d, vld_pipe_q;
  logic [CART_LENGTH-1:0]   abs_d, abs_q;
  logic signed [PROD_W-1:0] err_w, kp_w, ki_w;
  logic signed [PROD_W-1:0] prod_p_d, prod_p_q, prod_i_d, prod_i_q;

  // stage 2
  logic signed [DAC_LENGTH-1:0] dac_d, dac_q, pi_dac, ramp_dac;
  logic signed [ACC_LENGTH-1:0] integ_d, integ_q, integ_lo, integ_hi, integ_sum, integ_cl, preload;
  logic signed [SUM_W-1:0]      pi_sum, pi_shr, smin_s, smax_s;
  logic signed [DAC_LENGTH+1:0] ramp;
  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic                         vld1, in_lock, in_band;

`ifdef OPO_SERVO_DERIV_EN
  localparam int DIFF_W  = CART_LENGTH + 1;
  localparam int DPROD_W = DIFF_W + GAIN_LENGTH;
  logic signed [CART_LENGTH-1:0] err_d, err_q, err_prev_d, err_prev_q;
  logic signed [DIFF_W-1:0]      err_diff;
  logic signed [DPROD_W-1:0]     d_prod, kd_w, diff_w;
`endif

  assign vld1 = vld_pipe_q[0];

  // Stage 1: magnitude with most-negative saturation, full-precision gain products
  always_comb begin
    accept = err_valid && enable && (state_q != S_IDLE);
    err_w  = {{GAIN_LENGTH{err_in[CART_LENGTH-1]}}, err_in};
    kp_w   = {{CART_LENGTH{kp[GAIN_LENGTH-1]}}, kp};
    ki_w   = {{CART_LENGTH{ki[GAIN_LENGTH-1]}}, ki};
    if (!err_in[CART_LENGTH-1])              abs_d = err_in;
    else if (err_in[CART_LENGTH-2:0] == '0)  abs_d = ABS_MAX;
    else                                     abs_d = -err_in;
    prod_p_d   = kp_w * err_w;
    prod_i_d   = ki_w * err_w;
    vld_pipe_d = {vld_pipe_q[0] && enable, accept};
`ifdef OPO_SERVO_DERIV_EN
    err_d = err_in;
`endif
  end

  // Stage 1 registers; valid bits are flushed as soon as enable drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      abs_q      <= '0;
      prod_p_q   <= '0;
      prod_i_q   <= '0;
`ifdef OPO_SERVO_DERIV_EN
      err_q      <= '0;
`endif
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (accept) begin
        abs_q    <= abs_d;
        prod_p_q <= prod_p_d;
        prod_i_q <= prod_i_d;
`ifdef OPO_SERVO_DERIV_EN
        err_q    <= err_d;
`endif
      end
    end
  end

  // Stage 2 arithmetic: clamped integrator, PI output, sweep ramp, band tests
  always_comb begin
    integ_lo  = $signed({{(ACC_LENGTH-DAC_LENGTH){scan_min[DAC_LENGTH-1]}}, scan_min}) <<< SHIFT;
    integ_hi  = $signed({{(ACC_LENGTH-DAC_LENGTH){scan_max[DAC_LENGTH-1]}}, scan_max}) <<< SHIFT;
    preload   = $signed({{(ACC_LENGTH-DAC_LENGTH){dac_q[DAC_LENGTH-1]}}, dac_q}) <<< SHIFT;
    integ_sum = integ_q + $signed({{(ACC_LENGTH-PROD_W){prod_i_q[PROD_W-1]}}, prod_i_q});
    if (integ_sum < integ_lo)      integ_cl = integ_lo;
    else if (integ_sum > integ_hi) integ_cl = integ_hi;
    else                           integ_cl = integ_sum;
    pi_sum = $signed({{2{integ_cl[ACC_LENGTH-1]}}, integ_cl})
           + $signed({{(SUM_W-PROD_W){prod_p_q[PROD_W-1]}}, prod_p_q});
`ifdef OPO_SERVO_DERIV_EN
    err_diff = $signed({err_q[CART_LENGTH-1], err_q}) - $signed({err_prev_q[CART_LENGTH-1], err_prev_q});
    kd_w     = {{DIFF_W{kd[GAIN_LENGTH-1]}}, kd};
    diff_w   = {{GAIN_LENGTH{err_diff[DIFF_W-1]}}, err_diff};
    d_prod   = kd_w * diff_w;
    pi_sum   = pi_sum + $signed({{(SUM_W-DPROD_W){d_prod[DPROD_W-1]}}, d_prod});
`endif
    pi_shr = pi_sum >>> SHIFT;
    smin_s = $signed({{(SUM_W-DAC_LENGTH){scan_min[DAC_LENGTH-1]}}, scan_min});
    smax_s = $signed({{(SUM_W-DAC_LENGTH){scan_max[DAC_LENGTH-1]}}, scan_max});
    if (pi_shr < smin_s)      pi_dac = scan_min;
    else if (pi_shr > smax_s) pi_dac = scan_max;
    else                      pi_dac = pi_shr[DAC_LENGTH-1:0];
    ramp = $signed({{2{dac_q[DAC_LENGTH-1]}}, dac_q}) + $signed({2'b00, scan_step});
    ramp_dac = (ramp > $signed({{2{scan_max[DAC_LENGTH-1]}}, scan_max})) ? scan_min
                                                                          : ramp[DAC_LENGTH-1:0];
    in_lock = abs_q < lock_thresh;
    in_band = abs_q < unlock_thresh;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: enable low wins from any state
  always_comb begin
    state_d = state_q;
    if (!enable) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: state_d = S_SCAN;
        S_SCAN: if (vld1 && in_lock) state_d = S_ACQ;
        S_ACQ: if (vld1) begin
          if (!in_band)               state_d = S_SCAN;
          else if (cnt_q == LOCK_LAST) state_d = S_LOCK;
        end
        S_LOCK: if (vld1 && !in_band && (cnt_q == UNLOCK_LAST)) state_d = S_SCAN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stage 2 datapath update per state
  always_comb begin
    dac_d   = dac_q;
    integ_d = integ_q;
    cnt_d   = cnt_q;
`ifdef OPO_SERVO_DERIV_EN
    err_prev_d = err_prev_q;
    if (vld1) err_prev_d = (state_q == S_SCAN && in_lock) ? '0 : err_q;
`endif
    if (!enable) begin
      dac_d   = '0;
      integ_d = '0;
      cnt_d   = '0;
`ifdef OPO_SERVO_DERIV_EN
      err_prev_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          dac_d   = scan_min;
          integ_d = '0;
          cnt_d   = '0;
        end
        S_SCAN: if (vld1) begin
          if (in_lock) begin
            integ_d = preload;
            cnt_d   = '0;
          end else begin
            dac_d = ramp_dac;
          end
        end
        S_ACQ: if (vld1) begin
          if (!in_band) cnt_d = '0;
          else begin
            integ_d = integ_cl;
            dac_d   = pi_dac;
            cnt_d   = (state_d == S_LOCK) ? '0 : cnt_q + CNT_ONE;
          end
        end
        S_LOCK: if (vld1) begin
          if (state_d == S_SCAN) cnt_d = '0;
          else begin
            integ_d = integ_cl;
            dac_d   = pi_dac;
            cnt_d   = in_band ? '0 : cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac_q   <= '0;
      integ_q <= '0;
      cnt_q   <= '0;
`ifdef OPO_SERVO_DERIV_EN
      err_prev_q <= '0;
`endif
    end else begin
      dac_q   <= dac_d;
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
`ifdef OPO_SERVO_DERIV_EN
      err_prev_q <= err_prev_d;
`endif
    end
  end

  // FSM outputs
  always_comb begin
    state_out = state_q;
    locked    = (state_q == S_LOCK);
    dac_out   = dac_q;
    dac_valid = vld_pipe_q[1];
  end

endmodule

// File: tb/tb_opo_lock_servo.sv
// tb_opo_lock_servo: directed test-plan sequences then randomized traffic, every
// cycle compared against a transaction-level reference model of the servo rules.
module tb_opo_lock_servo;
  localparam int CL = 24, DL = 14, GL = 16, SH = 12, AL = 48, LC = 16, UC = 8;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, err_valid = 1'b0;
  logic signed [CL-1:0] err_in = '0;
  logic signed [GL-1:0] kp = '0, ki = '0;
`ifdef OPO_SERVO_DERIV_EN
  logic signed [GL-1:0] kd = '0;
`endif
  logic        [CL-1:0] lock_thresh = '0, unlock_thresh = '0;
  logic        [DL-1:0] scan_step = '0;
  logic signed [DL-1:0] scan_min = '0, scan_max = '0;
  logic signed [DL-1:0] dac_out;
  logic                 dac_valid, locked;
  logic [1:0]           state_out;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  opo_lock_servo #(.CART_LENGTH(CL), .DAC_LENGTH(DL), .GAIN_LENGTH(GL), .SHIFT(SH),
                   .ACC_LENGTH(AL), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_in(err_in), .err_valid(err_valid),
    .kp(kp), .ki(ki),
`ifdef OPO_SERVO_DERIV_EN
    .kd(kd),
`endif
    .lock_thresh(lock_thresh), .unlock_thresh(unlock_thresh), .scan_step(scan_step),
    .scan_min(scan_min), .scan_max(scan_max), .dac_out(dac_out), .dac_valid(dac_valid),
    .state_out(state_out), .locked(locked));

  // ---------------- reference model (0=IDLE 1=SCAN 2=ACQ 3=LOCK) ----------------
  typedef struct {longint e; longint kp; longint ki;} samp_t;
  samp_t  pend[$];
  int     m_state = 0;
  bit     m_valid = 0;
  longint m_dac = 0, m_integ = 0, m_cnt = 0, m_eprev = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic longint mag(input longint e);
    longint lim = longint'(1) <<< (CL - 1);
    if (e >= 0) return e;
    return (-e >= lim) ? lim - 1 : -e;
  endfunction

  task automatic model_clear();
    m_state = 0; m_valid = 0; m_dac = 0; m_integ = 0; m_cnt = 0; m_eprev = 0;
    pend.delete();
  endtask

  task automatic model_pi(input samp_t s);
    longint mn = scan_min, mx = scan_max, one = longint'(1) <<< SH, sum, q;
    m_integ = m_integ + s.ki * s.e;
    if (m_integ < mn * one) m_integ = mn * one;
    if (m_integ > mx * one) m_integ = mx * one;
    sum = s.kp * s.e + m_integ;
`ifdef OPO_SERVO_DERIV_EN
    sum = sum + longint'(kd) * (s.e - m_eprev);
`endif
    q = sum >>> SH;
    if (q < mn) q = mn;
    if (q > mx) q = mx;
    m_dac = q;
  endtask

  task automatic model_proc(input samp_t s);
    longint a = mag(s.e), lt = lock_thresh, ut = unlock_thresh, st = scan_step;
    longint mn = scan_min, mx = scan_max;
    bit entering = (m_state == 1) && (a < lt);
    case (m_state)
      1: if (a < lt) begin
           m_state = 2; m_integ = m_dac * (longint'(1) <<< SH); m_cnt = 0;
         end else begin
           m_dac = m_dac + st;
           if (m_dac > mx) m_dac = mn;
         end
      2: if (a < ut) begin
           m_cnt++; model_pi(s);
           if (m_cnt == LC) begin m_state = 3; m_cnt = 0; end
         end else begin
           m_state = 1; m_cnt = 0;
         end
      3: if (a >= ut) begin
           m_cnt++;
           if (m_cnt == UC) begin m_state = 1; m_cnt = 0; end
           else model_pi(s);
         end else begin
           m_cnt = 0; model_pi(s);
         end
      default: ;
    endcase
    m_eprev = entering ? 0 : s.e;
  endtask

  // called just after each rising edge with the inputs the DUT sampled
  task automatic model_edge();
    bit acc = err_valid && enable && (m_state != 0);
    samp_t s;
    if (!rst || !enable) begin model_clear(); return; end
    m_valid = 0;
    if (pend.size() > 0) begin
      s = pend.pop_front();
      m_valid = 1;
      model_proc(s);
    end else if (m_state == 0) begin
      m_state = 1; m_dac = scan_min;
    end
    if (acc) begin
      s.e = err_in; s.kp = kp; s.ki = ki;
      pend.push_back(s);
    end
  endtask

  task automatic cyc(input bit ev, input longint e);
    err_valid = ev;
    err_in    = e[CL-1:0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dac_valid", dac_valid, m_valid);
    chk("state_out", state_out, m_state);
    chk("locked", locked, m_state == 3);
    chk("dac_out", dac_out, m_dac);
  endtask

  initial begin
    int t, t2, amp;
    longint e;
    scan_min = -14'sd100; scan_max = 14'sd100; scan_step = 14'd60;
    lock_thresh = 24'd1000; unlock_thresh = 24'd2000;

    // reset held, then released with enable low: outputs stay zero
    for (int i = 0; i < 6; i++) cyc(i[0], 5000);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(i[0], 5000);
    chk("idle_dac", dac_out, 0);

    // sweep: -100 on entry, then -40, 20, 80, wrap -100, -40
    enable = 1'b1;
    cyc(0, 0);
    chk("scan_start", dac_out, -100);
    repeat (5) cyc(1, 5000);
    cyc(0, 0);
    chk("scan_after_wrap", dac_out, -40);

    // resonance at dac=20 -> ACQ holding 20, then 16 in-band -> LOCK
    cyc(1, 5000); cyc(1, 300); cyc(0, 0);
    chk("acq_hold_dac", dac_out, 20);
    chk("acq_state", state_out, 2);
    repeat (16) cyc(1, 0);
    chk("acq_15_not_locked", locked, 0);
    cyc(0, 0);
    chk("lock_16th", locked, 1);
    chk("lock_dac", dac_out, 20);

    // 7 out, 1 in, 7 out keeps lock; the 8th consecutive out drops it
    repeat (7) cyc(1, 3000);
    cyc(1, 0);
    repeat (7) cyc(1, 3000);
    cyc(0, 0);
    chk("lock_hold_7", locked, 1);
    cyc(1, 3000); cyc(0, 0);
    chk("lock_drop_8", state_out, 1);

    // relock, then a full-scale negative error with kp=1.0 clamps to scan_min
    cyc(1, 300);
    repeat (16) cyc(1, 0);
    cyc(0, 0);
    chk("relock", locked, 1);
    kp = 16'sd4096;
    cyc(1, -(longint'(1) <<< 23)); cyc(0, 0);
    chk("clamp_min", dac_out, -100);
    chk("clamp_still_lock", state_out, 3);
    kp = '0;
    repeat (3) cyc(1, 0);

    // enable drops with samples in flight
    enable = 1'b0;
    cyc(1, 0);
    chk("disable_state", state_out, 0);
    chk("disable_valid", dac_valid, 0);
    chk("disable_dac", dac_out, 0);
    repeat (3) cyc(1, 0);

    // randomized traffic
    for (int blk = 0; blk < 48; blk++) begin
      t  = -int'($urandom_range(6000, 0));
      t2 = t + 1 + int'($urandom_range(8191 - t - 1, 0) % 6000);
      scan_min  = t[DL-1:0];
      scan_max  = t2[DL-1:0];
      t = int'($urandom_range(3000, 1));        scan_step = t[DL-1:0];
      t = int'($urandom_range(4000, 100));      lock_thresh = t[CL-1:0];
      t = t + int'($urandom_range(6000, 0));    unlock_thresh = t[CL-1:0];
      t = int'($urandom_range(12000, 0)) - 6000; kp = t[GL-1:0];
      t = int'($urandom_range(4000, 0)) - 2000;  ki = t[GL-1:0];
`ifdef OPO_SERVO_DERIV_EN
      t = int'($urandom_range(4000, 0)) - 2000;  kd = t[GL-1:0];
`endif
      case ($urandom_range(3, 0))
        0: amp = 200;
        1: amp = 3000;
        2: amp = 20000;
        default: amp = 1 << 23;
      endcase
      enable = 1'b1;
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(199, 0) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(3, 0) == 0) enable = 1'b1;
        if ($urandom_range(31, 0) == 0) begin
          t = int'($urandom_range(12000, 0)) - 6000; kp = t[GL-1:0];
        end
        e = longint'($urandom_range(2 * amp, 0)) - amp;
        cyc($urandom_range(3, 0) != 0, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/opo_lock_servo.md
# opo_lock_servo

Lock-acquisition and PI servo stage downstream of the lock-in channel processing. It consumes the demodulated in-phase error (`x_out`, CART_LENGTH signed) with a valid strobe. While searching, it sweeps the actuator output; once a resonance is found, it closes a saturating PI loop and drives the 14-bit DAC word that steers the OPO cavity. It reports lock state to software.

## Interface
- CART_LENGTH, 24, width of signed error input
- DAC_LENGTH, 14, width of signed actuator output
- GAIN_LENGTH, 16, width of signed kp/ki (and kd)
- SHIFT, 12, fractional bits of gains; output = accumulated sum >>> SHIFT
- ACC_LENGTH, 48, integrator width (≥ CART_LENGTH+GAIN_LENGTH+4)
- LOCK_COUNT, 16, consecutive in-band samples needed in ACQ to declare lock
- UNLOCK_COUNT, 8, consecutive out-of-band samples in LOCK to drop lock
- clk  in  1  system clock; the single clock domain
- rst  in  1  asynchronous, active-low reset
- enable  in  1  servo enable; 0 forces IDLE
- err_in  in  CART_LENGTH  signed error sample
- err_valid  in  1  one-cycle strobe qualifying err_in
- kp, ki  in  GAIN_LENGTH  signed proportional/integral gains
- lock_thresh  in  CART_LENGTH  unsigned |err| threshold to leave SCAN
- unlock_thresh  in  CART_LENGTH  unsigned |err| threshold for lock loss (software sets ≥ lock_thresh)
- scan_step  in  DAC_LENGTH  unsigned ramp increment per sample
- scan_min, scan_max  in  DAC_LENGTH  signed output bounds (scan_min < scan_max)
- dac_out  out  DAC_LENGTH  signed actuator word
- dac_valid  out  1  strobe, one per accepted err_valid while not IDLE
- state_out  out  2  IDLE=0, SCAN=1, ACQ=2, LOCK=3
- locked  out  1  high only in LOCK

## Operation
- |err|: two's-complement magnitude; most-negative input saturates to 2^(CART_LENGTH-1)-1.
- IDLE: entered on reset or whenever enable=0, from any state, with immediate effect. Integrator, counters and dac_out are cleared to 0; no dac_valid. On enable=1, go to SCAN with dac_out loaded to scan_min.
- SCAN: per sample, dac_out += scan_step. If the result exceeds scan_max, dac_out wraps to scan_min. If |err| < lock_thresh, go to ACQ: the integrator is preloaded with dac_out << SHIFT, the counter is cleared, and dac_out holds for this sample.
- ACQ: PI active. Per sample, if |err| < unlock_thresh, increment the counter; reaching LOCK_COUNT moves to LOCK. Otherwise go to SCAN, continuing the ramp from the current dac_out.
- LOCK: PI active, locked=1. The out-of-band counter increments on |err| ≥ unlock_thresh and clears on any in-band sample. Reaching UNLOCK_COUNT moves to SCAN.
- PI arithmetic, full precision:
  - p = kp·err
  - integ += ki·err, clamped to [scan_min<<SHIFT, scan_max<<SHIFT] (anti-windup)
  - dac_out = clamp((p+integ) >>> SHIFT, scan_min, scan_max), arithmetic shift with truncation toward −∞
- Gains and thresholds are sampled per sample and may change at any time; no handshake.

## Timing
- 2-stage pipeline:
  - Stage 1 registers err, |err| and the products.
  - Stage 2 updates the integrator and counters, makes the state decision, and registers dac_out with dac_valid.
- dac_valid asserts exactly 2 cycles after err_valid.
- err_valid may assert every cycle; throughput is 1 sample/clk.
- enable falling: state_out=IDLE the next cycle. In-flight pipeline samples are discarded, producing no dac_valid.
- Reset (async assert, sync deassert by upstream) values: dac_out=0, dac_valid=0, state_out=0, locked=0, integrator=0.
- The state transition and the dac_out update caused by the same sample appear on the same cycle.

## Configuration
- OPO_SERVO_DERIV_EN defined:
  - Adds input kd (GAIN_LENGTH signed) and a derivative term kd·(err − err_prev).
  - err_prev is the previous valid sample, reset to 0 on entry to ACQ.
  - The term is added to p before the shift; latency is unchanged.
- Undefined: no kd port; pure PI.

## Test plan
- Reset with enable=0, err_valid pulsing → dac_out=0, dac_valid=0, state_out=0 throughout.
- enable=1, scan_min=-100, scan_max=100, scan_step=60, err=5000, lock_thresh=1000 → dac_out sequence -40, 20, 80, -100, -40; state SCAN.
- SCAN at dac_out=20, then err=300 → ACQ, dac_out holds 20. Then 16 samples err=0 with kp=ki=0 and LOCK_COUNT=16 → locked=1 on the 16th dac_valid, dac_out=20.
- In LOCK with unlock_thresh=2000: 7 samples err=3000, then 1 with err=0, then 8 with err=3000 → lock drops only on the 8th of the final run.
- kp=4096, ki=0, SHIFT=12, err=-(2^23) in LOCK → dac_out clamps to scan_min; no wrap.
- enable dropped with err_valid active every cycle in LOCK → state_out=0 next cycle, no further dac_valid, dac_out=0.
